// File: rtl/rv_mem_pkg.sv
// Shared constants and the load alignment/extension helper for the RV32 memory subsystem.
package rv_mem_pkg;

   localparam int          XLEN = 32;
   localparam logic [31:0] NOP  = 32'h0000_0013;

   localparam logic [3:0]  BE_B = 4'b0001;
   localparam logic [3:0]  BE_H = 4'b0011;
   localparam logic [3:0]  BE_W = 4'b1111;

   // Move the addressed bytes down to bit 0, keep the access size and extend.
   // Anything other than a byte or half access is treated as a full word.
   function automatic logic [31:0] load_extend(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [3:0]  be,
                                               input logic        is_signed);
      logic [31:0] sh;
      logic [31:0] res;
      sh = word >> {off, 3'b000};
      case (be)
         BE_B:    res = {{24{is_signed & sh[7]}}, sh[7:0]};
         BE_H:    res = {{16{is_signed & sh[15]}}, sh[15:0]};
         default: res = sh;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/rv_sram.sv
// Single-port 32-bit SRAM with 4-lane byte write enables and a registered,
// read-first output. Contents are never reset; only the read register is.
module rv_sram #(
   parameter int          DEPTH    = 256,
   parameter int          AW       = $clog2(DEPTH),
   parameter logic [31:0] RST_VAL  = 32'h0000_0000,
   parameter bit          WRITABLE = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic [3:0]    we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   generate
      if (WRITABLE) begin : g_wr
         // Write only the enabled byte lanes of the addressed word.
         always_ff @(posedge clk) begin
            for (int k = 0; k < 4; k++) begin
               if (we[k]) begin
                  mem[addr][8*k +: 8] <= wdata[8*k +: 8];
               end
            end
         end
      end else begin : g_ro
         logic unused_wr;
         assign unused_wr = ^{we, wdata};
      end
   endgenerate

   // Registered read of the old contents; holds when en is low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata <= RST_VAL;
      end else if (en) begin
         rdata <= mem[addr];
      end else begin
         rdata <= rdata;
      end
   end

endmodule

// File: rtl/rv_memory_wrap.sv
// Memory subsystem of the RV32 pipeline: word IMEM for fetch, byte-addressed DMEM
// for loads/stores. Optional simulation checks are enabled with RV_MEM_CHECK_EN.
module rv_memory_wrap
   import rv_mem_pkg::*;
#(
   parameter int IMEM_SIZE_WORDS = 256,
   parameter int DMEM_SIZE_BYTES = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_Q100H,
   input  logic        ready_Q101H,
   output logic [31:0] instruction_Q101H,
   input  logic [31:0] alu_out_Q103H,
   input  logic [31:0] dmem_wr_data_Q103H,
   input  logic        dmem_wr_en_Q103H,
   input  logic [3:0]  dmem_byte_en_Q103H,
   input  logic        dmem_is_signed_Q103H,
   output logic [31:0] dmem_rd_data_Q104H
);

   localparam int IAW = $clog2(IMEM_SIZE_WORDS);
   localparam int DAW = $clog2(DMEM_SIZE_BYTES / 4);

   logic [1:0]     off;
   logic [DAW-1:0] widx;
   logic [6:0]     mask_wide;
   logic [3:0]     lane_mask;
   logic [31:0]    wr_data_sh;
   logic [31:0]    rd_word;
   logic [1:0]     off_q104;
   logic [3:0]     be_q104;
   logic           signed_q104;
   logic           unused_addr;

   assign off  = alu_out_Q103H[1:0];
   assign widx = alu_out_Q103H[2 +: DAW];

   // Bits that only select beyond the array depth are ignored (addresses wrap).
   assign unused_addr = ^{pc_Q100H[1:0], pc_Q100H[31:2+IAW], alu_out_Q103H[31:2+DAW]};

   rv_sram #(
      .DEPTH    (IMEM_SIZE_WORDS),
      .AW       (IAW),
      .RST_VAL  (NOP),
      .WRITABLE (1'b0)
   ) i_mem (
      .clk   (clk),
      .rst   (rst),
      .en    (ready_Q101H),
      .we    (4'b0000),
      .addr  (pc_Q100H[2 +: IAW]),
      .wdata (32'h0000_0000),
      .rdata (instruction_Q101H)
   );

   // Align store data and lane mask to the byte offset; lanes past 3 fall off.
   always_comb begin
      mask_wide  = {3'b000, dmem_byte_en_Q103H} << off;
      wr_data_sh = dmem_wr_data_Q103H << {off, 3'b000};
      if (dmem_wr_en_Q103H) begin
         lane_mask = mask_wide[3:0];
      end else begin
         lane_mask = 4'b0000;
      end
   end

   rv_sram #(
      .DEPTH    (DMEM_SIZE_BYTES / 4),
      .AW       (DAW),
      .RST_VAL  (32'h0000_0000),
      .WRITABLE (1'b1)
   ) u_dmem (
      .clk   (clk),
      .rst   (rst),
      .en    (1'b1),
      .we    (lane_mask),
      .addr  (widx),
      .wdata (wr_data_sh),
      .rdata (rd_word)
   );

   // Carry the load shape alongside the registered read word into Q104.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         off_q104    <= 2'b00;
         be_q104     <= 4'b0000;
         signed_q104 <= 1'b0;
      end else begin
         off_q104    <= off;
         be_q104     <= dmem_byte_en_Q103H;
         signed_q104 <= dmem_is_signed_Q103H;
      end
   end

   assign dmem_rd_data_Q104H = load_extend(rd_word, off_q104, be_q104, signed_q104);

`ifdef RV_MEM_CHECK_EN
   rv_mem_checker #(
      .IMEM_SIZE_WORDS (IMEM_SIZE_WORDS),
      .DMEM_SIZE_BYTES (DMEM_SIZE_BYTES)
   ) u_check (
      .clk   (clk),
      .rst   (rst),
      .pc    (pc_Q100H),
      .ready (ready_Q101H),
      .addr  (alu_out_Q103H),
      .be    (dmem_byte_en_Q103H)
   );
`endif

endmodule

`ifdef RV_MEM_CHECK_EN
// Simulation-only access checker: misalignment, illegal size, out-of-range address.
module rv_mem_checker
   import rv_mem_pkg::*;
#(
   parameter int IMEM_SIZE_WORDS = 256,
   parameter int DMEM_SIZE_BYTES = 1024
) (
   input logic        clk,
   input logic        rst,
   input logic [31:0] pc,
   input logic        ready,
   input logic [31:0] addr,
   input logic [3:0]  be
);
   localparam int IBW = $clog2(IMEM_SIZE_WORDS) + 2;
   localparam int DBW = $clog2(DMEM_SIZE_BYTES);

   // Report every violating access with its address.
   always @(posedge clk) begin
      if (!rst) begin
         if ((be == BE_H && addr[0]) || (be == BE_W && addr[1:0] != 2'b00))
            $error("rv_mem: misaligned access addr=%08h be=%b", addr, be);
         if (be != BE_B && be != BE_H && be != BE_W)
            $error("rv_mem: illegal byte_en addr=%08h be=%b", addr, be);
         if ((addr >> DBW) != 32'h0)
            $error("rv_mem: DMEM address out of range addr=%08h", addr);
         if (ready && ((pc >> IBW) != 32'h0))
            $error("rv_mem: IMEM address out of range pc=%08h", pc);
      end
   end
endmodule
`endif

// File: tb/tb_rv_memory_wrap.sv
// Randomised self-checking bench for rv_memory_wrap against a byte-level memory model.
module tb_rv_memory_wrap;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_Q100H;
   logic        ready_Q101H;
   logic [31:0] instruction_Q101H;
   logic [31:0] alu_out_Q103H;
   logic [31:0] dmem_wr_data_Q103H;
   logic        dmem_wr_en_Q103H;
   logic [3:0]  dmem_byte_en_Q103H;
   logic        dmem_is_signed_Q103H;
   logic [31:0] dmem_rd_data_Q104H;

   int total = 0;
   int bad   = 0;

   logic [7:0]  dmem_m [1024];
   logic [31:0] imem_m [256];

   always #5 clk = ~clk;

   rv_memory_wrap dut (
      .clk                  (clk),
      .rst                  (rst),
      .pc_Q100H             (pc_Q100H),
      .ready_Q101H          (ready_Q101H),
      .instruction_Q101H    (instruction_Q101H),
      .alu_out_Q103H        (alu_out_Q103H),
      .dmem_wr_data_Q103H   (dmem_wr_data_Q103H),
      .dmem_wr_en_Q103H     (dmem_wr_en_Q103H),
      .dmem_byte_en_Q103H   (dmem_byte_en_Q103H),
      .dmem_is_signed_Q103H (dmem_is_signed_Q103H),
      .dmem_rd_data_Q104H   (dmem_rd_data_Q104H)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Reference load: bytes starting at the offset inside the (wrapped) word,
   // bytes past the end of the word read as zero, then size/sign handling.
   function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [3:0] be,
                                            input logic sgn);
      int unsigned base, off, n;
      logic [31:0] val;
      base = (a % 1024) & ~32'd3;
      off  = a % 4;
      n    = (be == 4'b0001) ? 1 : (be == 4'b0011) ? 2 : 4;
      val  = 32'h0;
      for (int i = 0; i < 4; i++) begin
         if (i < n && off + i < 4) val[8*i +: 8] = dmem_m[base + off + i];
      end
      if (sgn && n < 4 && val[8*n-1]) begin
         for (int b = 8*n; b < 32; b++) val[b] = 1'b1;
      end
      return val;
   endfunction

   task automatic ref_store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
      int unsigned base, off;
      base = (a % 1024) & ~32'd3;
      off  = a % 4;
      for (int k = 0; k < 4; k++) begin
         if (be[k] && off + k < 4) dmem_m[base + off + k] = d[8*k +: 8];
      end
   endtask

   // One DMEM cycle: drive, predict (read-first), update model, clock, compare.
   task automatic mem_op(input string tag, input logic [31:0] a, input logic wr,
                         input logic [31:0] d, input logic [3:0] be, input logic sgn,
                         input bit do_check, output logic [31:0] got);
      logic [31:0] exp;
      alu_out_Q103H        = a;
      dmem_wr_en_Q103H     = wr;
      dmem_wr_data_Q103H   = d;
      dmem_byte_en_Q103H   = be;
      dmem_is_signed_Q103H = sgn;
      exp = ref_load(a, be, sgn);
      if (wr) ref_store(a, be, d);
      @(posedge clk);
      #1;
      got = dmem_rd_data_Q104H;
      dmem_wr_en_Q103H = 1'b0;
      if (do_check) check(tag, got, exp);
   endtask

   task automatic fetch(input logic [31:0] pc, input logic rdy);
      pc_Q100H    = pc;
      ready_Q101H = rdy;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] got, prev, a, pc;
      logic [3:0]  be;
      logic        rdy, wr;

      rst = 1'b1;
      pc_Q100H = 32'h0; ready_Q101H = 1'b0;
      alu_out_Q103H = 32'h0; dmem_wr_data_Q103H = 32'h0; dmem_wr_en_Q103H = 1'b0;
      dmem_byte_en_Q103H = 4'b1111; dmem_is_signed_Q103H = 1'b0;

      for (int i = 0; i < 256; i++) begin
         imem_m[i] = $urandom;
         if (i < 5) imem_m[i] = 32'h11 * (i + 1);
         dut.i_mem.mem[i] = imem_m[i];
      end

      repeat (2) @(posedge clk);
      #1;
      check("reset_instr", instruction_Q101H, 32'h0000_0013);
      check("reset_rd", dmem_rd_data_Q104H, 32'h0000_0000);
      @(negedge clk);
      rst = 1'b0;
      #1;

      // IMEM sequential fetch
      for (int i = 0; i < 5; i++) begin
         fetch(32'(4 * i), 1'b1);
         check("imem_seq", instruction_Q101H, 32'h11 * (i + 1));
      end

      // Hold while not ready
      fetch(32'h8, 1'b1);
      check("imem_pc8", instruction_Q101H, 32'h33);
      fetch(32'hC, 1'b0);
      check("imem_hold1", instruction_Q101H, 32'h33);
      fetch(32'h10, 1'b0);
      check("imem_hold2", instruction_Q101H, 32'h33);

      // Asynchronous reset mid-run
      #2;
      rst = 1'b1;
      #1;
      check("imem_async_rst", instruction_Q101H, 32'h0000_0013);
      check("dmem_async_rst", dmem_rd_data_Q104H, 32'h0000_0000);
      @(negedge clk);
      rst = 1'b0;
      #1;

      // Random fetches with wrapping PCs
      prev = 32'h0000_0013;
      for (int i = 0; i < 60; i++) begin
         pc  = $urandom;
         rdy = 1'($urandom_range(0, 3) != 0);
         fetch(pc, rdy);
         if (rdy) prev = imem_m[pc[9:2]];
         check("imem_rand", instruction_Q101H, prev);
      end
      ready_Q101H = 1'b0;

      // Fill DMEM through the store port so the model knows every byte
      for (int i = 0; i < 256; i++) begin
         mem_op("fill", 32'(4 * i), 1'b1, $urandom, 4'b1111, 1'b0, 1'b0, got);
      end

      // Word store then word load
      mem_op("w_st", 32'h10, 1'b1, 32'hDEAD_BEEF, 4'b1111, 1'b0, 1'b1, got);
      mem_op("w_ld", 32'h10, 1'b0, 32'h0, 4'b1111, 1'b0, 1'b1, got);
      check("w_ld_const", got, 32'hDEAD_BEEF);

      // Byte store, signed/unsigned byte loads, word view
      mem_op("b_st", 32'h21, 1'b1, 32'h0000_0080, 4'b0001, 1'b0, 1'b1, got);
      mem_op("b_ld_s", 32'h21, 1'b0, 32'h0, 4'b0001, 1'b1, 1'b1, got);
      check("b_ld_s_const", got, 32'hFFFF_FF80);
      mem_op("b_ld_u", 32'h21, 1'b0, 32'h0, 4'b0001, 1'b0, 1'b1, got);
      check("b_ld_u_const", got, 32'h0000_0080);
      mem_op("b_ld_w", 32'h20, 1'b0, 32'h0, 4'b1111, 1'b0, 1'b1, got);
      check("b_ld_w_lane1", {24'h0, got[15:8]}, 32'h0000_0080);

      // Half store, signed load, same-cycle read-first behaviour
      mem_op("h_st", 32'h32, 1'b1, 32'h0000_8001, 4'b0011, 1'b0, 1'b1, got);
      mem_op("h_ld_s", 32'h32, 1'b0, 32'h0, 4'b0011, 1'b1, 1'b1, got);
      check("h_ld_s_const", got, 32'hFFFF_8001);
      mem_op("h_rw_old", 32'h32, 1'b1, 32'h0000_1234, 4'b0011, 1'b1, 1'b1, got);
      check("h_rw_old_const", got, 32'hFFFF_8001);
      mem_op("h_rw_new", 32'h32, 1'b0, 32'h0, 4'b0011, 1'b1, 1'b1, got);
      check("h_rw_new_const", got, 32'h0000_1234);

      // Out-of-range store wraps to word 0
      mem_op("wrap_st", 32'h400, 1'b1, 32'hCAFE_F00D, 4'b1111, 1'b0, 1'b1, got);
      mem_op("wrap_ld", 32'h0, 1'b0, 32'h0, 4'b1111, 1'b0, 1'b1, got);
      check("wrap_ld_const", got, 32'hCAFE_F00D);

      // Random mixed traffic, including misaligned and illegal sizes
      for (int i = 0; i < 400; i++) begin
         a = (i % 2 == 0) ? 32'($urandom_range(0, 2047)) : $urandom;
         case ($urandom_range(0, 3))
            0: be = 4'b0001;
            1: be = 4'b0011;
            2: be = 4'b1111;
            default: be = 4'($urandom);
         endcase
         wr = 1'($urandom);
         mem_op("rand", a, wr, $urandom, be, 1'($urandom), 1'b1, got);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
